// File: rtl/svm_pkg.sv
// svm_pkg: shared types and helpers for the SVM processing element.
//   svm_st_e       : controller states IDLE -> RUN -> DRAIN -> BIAS -> DONE
//   svm_clog2()    : address width helper, never returns less than 1
//   SVM_DRAIN_LAST : last DRAIN count value; the flush needs one more cycle
//                    when the SVM_ALPHA_EN coefficient stage is built
package svm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    BIAS  = 3'd3,
    DONE  = 3'd4
  } svm_st_e;

  function automatic int svm_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int SVM_MAX_SV = 64;
  localparam int SVM_SV_AW  = svm_clog2(SVM_MAX_SV);

`ifdef SVM_ALPHA_EN
  localparam logic [1:0] SVM_DRAIN_LAST = 2'd2;
`else
  localparam logic [1:0] SVM_DRAIN_LAST = 2'd1;
`endif

endpackage

// File: rtl/svm_dot_lane.sv
// svm_dot_lane: registered signed dot product of two N_FEAT-feature vectors.
//   CLK, RESETn : clock, synchronous active-low reset
//   in_vld      : feat_a/feat_b hold a valid pair this cycle
//   feat_a/b    : packed features, feature i at [i*FEAT_W +: FEAT_W]
//   out_vld     : dot holds the result of the pair presented last cycle
//   dot         : sum of products, sign-extended to ACC_W
module svm_dot_lane #(
  parameter int N_FEAT = 4,
  parameter int FEAT_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                       CLK,
  input  logic                       RESETn,
  input  logic                       in_vld,
  input  logic [N_FEAT*FEAT_W-1:0]   feat_a,
  input  logic [N_FEAT*FEAT_W-1:0]   feat_b,
  output logic                       out_vld,
  output logic signed [ACC_W-1:0]    dot
);

  localparam int PW = 2*FEAT_W;

  logic signed [PW-1:0]    prod [N_FEAT];
  logic signed [ACC_W-1:0] sum;

  for (genvar i = 0; i < N_FEAT; i++) begin : g_mul
    assign prod[i] = PW'($signed(feat_a[i*FEAT_W +: FEAT_W])) *
                     PW'($signed(feat_b[i*FEAT_W +: FEAT_W]));
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_FEAT; i++) sum = sum + ACC_W'(prod[i]);
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      out_vld <= 1'b0;
      dot     <= '0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) dot <= sum;
    end
  end

endmodule

// File: rtl/svm_pe_param.sv
// svm_pe_param: pipelined SVM classification element, one support vector
// per cycle. Latches a sample, streams n_sv support vectors from a
// synchronous memory, accumulates the dot products, adds a signed bias and
// reports score and class (score > 0).
//   CLK, RESETn           : clock, synchronous active-low reset
//   start                 : request, honoured only while idle
//   sample_data/bias/n_sv : latched at accepted start (n_sv clamped to N_SV)
//   sv_addr, sv_rd        : memory read port, data returns one cycle later
//   sv_data               : features, plus alpha above them with SVM_ALPHA_EN
//   busy                  : high while a classification is in progress
//   score, sample_classification : result, held until the next start
//   classify_sample_done  : one-cycle pulse when the result is valid
// Build option: SVM_ALPHA_EN adds a signed per-SV coefficient stage.
module svm_pe_param
  import svm_pkg::*;
#(
  parameter int N_FEAT  = 4,
  parameter int FEAT_W  = 8,
  parameter int N_SV    = 64,
  parameter int ACC_W   = 32,
  parameter int BIAS_W  = 16,
  parameter int ALPHA_W = 8,
  localparam int AW = svm_clog2(N_SV),
  localparam int NW = AW + 1,
  localparam int FW = N_FEAT*FEAT_W,
`ifdef SVM_ALPHA_EN
  localparam int DW = FW + ALPHA_W
`else
  // ALPHA_W contributes nothing when the coefficient field is absent
  localparam int DW = FW + 0*ALPHA_W
`endif
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic                     start,
  input  logic [FW-1:0]            sample_data,
  input  logic signed [BIAS_W-1:0] bias,
  input  logic [NW-1:0]            n_sv,
  output logic [AW-1:0]            sv_addr,
  output logic                     sv_rd,
  input  logic [DW-1:0]            sv_data,
  output logic                     busy,
  output logic signed [ACC_W-1:0]  score,
  output logic                     sample_classification,
  output logic                     classify_sample_done
);

  svm_st_e                  state;
  logic [FW-1:0]            sample_q;
  logic signed [BIAS_W-1:0] bias_q;
  logic [NW-1:0]            cnt;
  logic [AW-1:0]            addr;
  logic [1:0]               drain_cnt;
  logic [NW-1:0]            n_clamp;

  logic                     rd_vld;
  logic                     dot_vld;
  logic signed [ACC_W-1:0]  dot;
  logic                     acc_vld;
  logic signed [ACC_W-1:0]  acc_term;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  score_nxt;

  assign n_clamp = (n_sv > NW'(N_SV)) ? NW'(N_SV) : n_sv;

  assign sv_rd                = (state == RUN);
  assign sv_addr              = addr;
  assign busy                 = (state != IDLE);
  assign classify_sample_done = (state == DONE);

  // ---- controller ----
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state     <= IDLE;
      sample_q  <= '0;
      bias_q    <= '0;
      cnt       <= '0;
      addr      <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sample_q  <= sample_data;
          bias_q    <= bias;
          cnt       <= n_clamp;
          addr      <= '0;
          drain_cnt <= '0;
          state     <= (n_clamp == '0) ? DRAIN : RUN;
        end
        RUN: begin
          if ({1'b0, addr} == cnt - 1'b1) begin
            addr  <= '0;
            state <= DRAIN;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        DRAIN: begin
          // covers the lane (and alpha) register plus the accumulator add
          if (drain_cnt == SVM_DRAIN_LAST) begin
            drain_cnt <= '0;
            state     <= BIAS;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        BIAS:    state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- datapath ----
  always_ff @(posedge CLK) begin
    if (!RESETn) rd_vld <= 1'b0;
    else         rd_vld <= sv_rd;
  end

  svm_dot_lane #(
    .N_FEAT (N_FEAT),
    .FEAT_W (FEAT_W),
    .ACC_W  (ACC_W)
  ) u_lane (
    .CLK     (CLK),
    .RESETn  (RESETn),
    .in_vld  (rd_vld),
    .feat_a  (sv_data[FW-1:0]),
    .feat_b  (sample_q),
    .out_vld (dot_vld),
    .dot     (dot)
  );

`ifdef SVM_ALPHA_EN
  // alpha is captured on the same edge as the lane products so it lines up
  // with dot on the following cycle
  logic signed [ALPHA_W-1:0] alpha_q;
  logic signed [ACC_W-1:0]   term;
  logic                      term_vld;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      alpha_q  <= '0;
      term     <= '0;
      term_vld <= 1'b0;
    end else begin
      alpha_q  <= sv_data[FW +: ALPHA_W];
      term_vld <= dot_vld;
      if (dot_vld) term <= dot * ACC_W'(alpha_q);
    end
  end

  assign acc_term = term;
  assign acc_vld  = term_vld;
`else
  assign acc_term = dot;
  assign acc_vld  = dot_vld;
`endif

  always_ff @(posedge CLK) begin
    if (!RESETn)                     acc <= '0;
    else if (state == IDLE && start) acc <= '0;
    else if (acc_vld)                acc <= acc + acc_term;
  end

  // ---- bias and decision ----
  assign score_nxt = acc + ACC_W'(bias_q);

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      score                 <= '0;
      sample_classification <= 1'b0;
    end else if (state == BIAS) begin
      score                 <= score_nxt;
      // zero is not a positive score
      sample_classification <= !score_nxt[ACC_W-1] && (score_nxt != '0);
    end
  end

endmodule

// File: tb/tb_svm_pe_param.sv
// tb_svm_pe_param: directed bench for svm_pe_param with a transaction-level
// model (expected score from plain integer sums over the memory contents,
// expected timing from the start cycle and clamped count) compared against
// the DUT every cycle, plus literal expectations for the key scenarios.
module tb_svm_pe_param;

  localparam int N_FEAT  = 4;
  localparam int FEAT_W  = 8;
  localparam int N_SV    = 64;
  localparam int ACC_W   = 32;
  localparam int BIAS_W  = 16;
  localparam int ALPHA_W = 8;
  localparam int FW      = N_FEAT*FEAT_W;
  localparam int AW      = 6;
  localparam int NW      = 7;
`ifdef SVM_ALPHA_EN
  localparam int DW  = FW + ALPHA_W;
  localparam int LAT = 5;
`else
  localparam int DW  = FW;
  localparam int LAT = 4;
`endif

  logic                     CLK = 1'b0;
  logic                     RESETn;
  logic                     start;
  logic [FW-1:0]            sample_data;
  logic signed [BIAS_W-1:0] bias;
  logic [NW-1:0]            n_sv;
  logic [AW-1:0]            sv_addr;
  logic                     sv_rd;
  logic [DW-1:0]            sv_data;
  logic                     busy;
  logic signed [ACC_W-1:0]  score;
  logic                     sample_classification;
  logic                     classify_sample_done;

  svm_pe_param #(
    .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .N_SV(N_SV),
    .ACC_W(ACC_W), .BIAS_W(BIAS_W), .ALPHA_W(ALPHA_W)
  ) dut (
    .CLK(CLK), .RESETn(RESETn), .start(start), .sample_data(sample_data),
    .bias(bias), .n_sv(n_sv), .sv_addr(sv_addr), .sv_rd(sv_rd),
    .sv_data(sv_data), .busy(busy), .score(score),
    .sample_classification(sample_classification),
    .classify_sample_done(classify_sample_done)
  );

  always #5 CLK = ~CLK;

  // synchronous support-vector memory
  logic [DW-1:0] mem [N_SV];
  always @(posedge CLK) if (sv_rd) sv_data <= mem[sv_addr];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int reads  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mkw(input int f0, input int f1,
                                        input int f2, input int f3, input int a);
    logic [DW-1:0] w;
    w = '0;
    w[0*FEAT_W +: FEAT_W] = FEAT_W'(f0);
    w[1*FEAT_W +: FEAT_W] = FEAT_W'(f1);
    w[2*FEAT_W +: FEAT_W] = FEAT_W'(f2);
    w[3*FEAT_W +: FEAT_W] = FEAT_W'(f3);
`ifdef SVM_ALPHA_EN
    w[FW +: ALPHA_W] = ALPHA_W'(a);
`else
    if (a != 1) w = '0; // coefficient is implicitly +1 in this build
`endif
    return w;
  endfunction

  function automatic logic [FW-1:0] mks(input int f0, input int f1,
                                        input int f2, input int f3);
    logic [FW-1:0] s;
    s = {FEAT_W'(f3), FEAT_W'(f2), FEAT_W'(f1), FEAT_W'(f0)};
    return s;
  endfunction

  // bias + sum over SVs of (sample . sv) * alpha, wrapped to ACC_W
  function automatic logic signed [ACC_W-1:0] model_score(
      input logic [FW-1:0] s, input logic [BIAS_W-1:0] b, input int nc);
    longint tot, d;
    tot = longint'($signed(b));
    for (int k = 0; k < nc; k++) begin
      d = 0;
      for (int i = 0; i < N_FEAT; i++)
        d += longint'($signed(s[i*FEAT_W +: FEAT_W])) *
             longint'($signed(mem[k][i*FEAT_W +: FEAT_W]));
`ifdef SVM_ALPHA_EN
      d = d * longint'($signed(mem[k][FW +: ALPHA_W]));
`endif
      tot += d;
    end
    return tot[ACC_W-1:0];
  endfunction

  function automatic int clampn(input logic [NW-1:0] n);
    return (int'(n) > N_SV) ? N_SV : int'(n);
  endfunction

  // transaction model state
  bit                      active = 1'b0;
  int                      t0 = 0;
  int                      m_n = 0;
  logic signed [ACC_W-1:0] exp_score = '0;
  logic                    exp_cls = 1'b0;
  logic signed [ACC_W-1:0] last_score = '0;
  logic                    last_cls = 1'b0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (sv_rd) reads <= reads + 1;
    if (!RESETn) begin
      active     <= 1'b0;
      last_score <= '0;
      last_cls   <= 1'b0;
    end else if (active && cyc == t0 + m_n + LAT) begin
      active     <= 1'b0;
      last_score <= exp_score;
      last_cls   <= exp_cls;
    end else if (!active && start) begin
      active    <= 1'b1;
      t0        <= cyc;
      m_n       <= clampn(n_sv);
      exp_score <= model_score(sample_data, bias, clampn(n_sv));
      exp_cls   <= (model_score(sample_data, bias, clampn(n_sv)) > 0);
    end
  end

  // per-cycle comparison against the model
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("busy", busy, active);
      chk("sv_rd", sv_rd, active && cyc > t0 && cyc <= t0 + m_n);
      if (active && cyc > t0 && cyc <= t0 + m_n)
        chk("sv_addr", sv_addr, cyc - t0 - 1);
      chk("done", classify_sample_done, active && cyc == t0 + m_n + LAT);
      if (active && cyc == t0 + m_n + LAT) begin
        chk("score", score, exp_score);
        chk("class", sample_classification, exp_cls);
      end else begin
        chk("score_hold", score, last_score);
        chk("class_hold", sample_classification, last_cls);
      end
    end
  end

  // poke=1: pulse start and change sample_data during RUN
  task automatic run_job(input logic [FW-1:0] s, input int b, input int n,
                         input bit poke, output int t_acc, output int lat);
    @(negedge CLK);
    sample_data = s;
    bias        = BIAS_W'(b);
    n_sv        = NW'(n);
    start       = 1'b1;
    t_acc       = cyc;
    lat         = -1;
    for (int k = 0; k < 300 && lat < 0; k++) begin
      @(negedge CLK);
      if (poke && k == 1) begin
        start       = 1'b1;
        sample_data = ~s;
        bias        = BIAS_W'(b + 3);
        n_sv        = NW'(1);
      end else begin
        start = 1'b0;
      end
      if (classify_sample_done) lat = cyc - t_acc;
    end
    start = 1'b0;
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  int ta, lat, r0;

  initial begin
    RESETn = 1'b0; start = 1'b0; sample_data = '0; bias = '0; n_sv = '0;
    for (int k = 0; k < 4; k++)  mem[k] = mkw(1, 1, 1, 1, 1);
    for (int k = 4; k < N_SV; k++)
      mem[k] = mkw(k - 32, 17 - (k % 35), (k * 7) % 23 - 11, -(k % 9), (k % 3) - 1);
    repeat (3) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_rd", sv_rd, 0);
    chk("rst_addr", sv_addr, 0);
    chk("rst_score", score, 0);
    chk("rst_done", classify_sample_done, 0);
    chk_en = 1'b1;
    RESETn = 1'b1;

    // 4 SVs of all +1, sample (2,3,4,5): 4*14 - 50 = 6
    run_job(mks(2, 3, 4, 5), -50, 4, 1'b0, ta, lat);
    chk("t1_score", score, 6);
    chk("t1_class", sample_classification, 1);
    chk("t1_lat", lat, LAT + 4);

    // zero boundary: 56 - 56 = 0 -> class 0
    run_job(mks(2, 3, 4, 5), -56, 4, 1'b0, ta, lat);
    chk("t2_score", score, 0);
    chk("t2_class", sample_classification, 0);

    // empty run: score = bias, no reads
    r0 = reads;
    run_job(mks(9, 9, 9, 9), 7, 0, 1'b0, ta, lat);
    chk("t3_score", score, 7);
    chk("t3_class", sample_classification, 1);
    chk("t3_lat", lat, LAT);
    chk("t3_reads", reads - r0, 0);

    // clamped count: 100 -> 64 reads
    r0 = reads;
    run_job(mks(3, -2, 1, 5), 100, 100, 1'b0, ta, lat);
    chk("t4_reads", reads - r0, 64);
    chk("t4_lat", lat, LAT + 64);

    // mixed-sign extremes, partial count
    run_job(mks(-7, 100, -128, 127), 1000, 9, 1'b0, ta, lat);
    chk("t5_lat", lat, LAT + 9);

    // start and input changes while busy are ignored
    run_job(mks(2, 3, 4, 5), -50, 4, 1'b1, ta, lat);
    chk("t6_score", score, 6);
    chk("t6_lat", lat, LAT + 4);

    // reset in cycle T+5 aborts without a done pulse
    @(negedge CLK);
    sample_data = mks(1, 1, 1, 1); bias = BIAS_W'(20); n_sv = NW'(10);
    start = 1'b1; ta = cyc;
    @(negedge CLK);
    start = 1'b0;
    while (cyc < ta + 5) @(negedge CLK);
    RESETn = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
    chk("t7_busy", busy, 0);
    chk("t7_score", score, 0);
    repeat (20) @(negedge CLK);

    // recovers after reset
    run_job(mks(2, 3, 4, 5), -50, 4, 1'b0, ta, lat);
    chk("t8_score", score, 6);

`ifdef SVM_ALPHA_EN
    // -1 * 4 * (-128 * -128) + 5 = -65531
    mem[0] = mkw(-128, -128, -128, -128, -1);
    run_job(mks(-128, -128, -128, -128), 5, 1, 1'b0, ta, lat);
    chk("t9_score", score, -65531);
    chk("t9_class", sample_classification, 0);
    chk("t9_lat", lat, 6);
`endif

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
